// File: rtl/dac_frame_rx.sv
// dac_frame_rx: receives 24-bit DAC serial frames (8 control bits + 16 data bits, MSB first) framed by SYNC.
// Optional DAC_FRAME_RX_CTRL_CHECK_EN: reject frames whose control byte is non-zero.
module dac_frame_rx (
  input  logic               CLK_50,
  input  logic               RESET_N,
  input  logic               SYNC,
  input  logic               SCLK,
  input  logic               DIN,
  output logic signed [23:0] DATA24,
  output logic [7:0]         CTRL8,
  output logic               VALID,
  output logic               FRAME_ERR,
  output logic [7:0]         ERR_CNT,
  output logic               BUSY
);
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
  state_t      state;
  logic [2:0]  sync_q;
  logic [2:0]  sclk_q;
  logic [1:0]  din_q;
  logic [23:0] sr;
  logic [4:0]  cnt;
  logic [1:0]  warm;
  logic        sync_fall;
  logic        sync_rise;
  logic        sclk_rise;
  logic        accept;
  // Falls are trusted only once the whole SYNC chain holds real samples, so a
  // frame already in progress at reset release is never picked up.
  assign sync_fall = sync_q[2] & ~sync_q[1] & (warm == 2'd3);
  assign sync_rise = sync_q[1] & ~sync_q[2];
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
`ifdef DAC_FRAME_RX_CTRL_CHECK_EN
  assign accept = (cnt == 5'd24) && (sr[23:16] == 8'h00);
`else
  assign accept = (cnt == 5'd24);
`endif
  always_ff @(posedge CLK_50) begin
    if (!RESET_N) begin
      sync_q    <= 3'b111;
      sclk_q    <= 3'b000;
      din_q     <= 2'b00;
      warm      <= 2'd0;
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      DATA24    <= '0;
      CTRL8     <= '0;
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;
      ERR_CNT   <= '0;
      BUSY      <= 1'b0;
    end else begin
      sync_q    <= {sync_q[1:0], SYNC};
      sclk_q    <= {sclk_q[1:0], SCLK};
      din_q     <= {din_q[0], DIN};
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;
      if (warm != 2'd3) warm <= warm + 2'd1;
      case (state)
        IDLE: if (sync_fall) begin
          sr    <= '0;
          cnt   <= '0;
          BUSY  <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: if (sync_rise) state <= CHECK;
        else if (sclk_rise) begin
          sr <= {sr[22:0], din_q[1]};
          if (cnt != 5'd31) cnt <= cnt + 5'd1;
        end
        CHECK: begin
          VALID     <= accept;
          FRAME_ERR <= ~accept;
          if (accept) begin
            DATA24 <= {sr[15:0], 8'h00};
            CTRL8  <= sr[23:16];
          end else if (ERR_CNT != 8'hff) ERR_CNT <= ERR_CNT + 8'd1;
          sr    <= '0;
          cnt   <= '0;
          BUSY  <= sync_fall;
          state <= sync_fall ? SHIFT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dac_frame_rx.sv
// tb_dac_frame_rx: directed checks of dac_frame_rx framing, errors, saturation, reset and back-to-back frames.
module tb_dac_frame_rx;
  logic               CLK_50 = 1'b0;
  logic               RESET_N = 1'b0;
  logic               SYNC = 1'b1;
  logic               SCLK = 1'b0;
  logic               DIN = 1'b0;
  logic signed [23:0] DATA24;
  logic [7:0]         CTRL8;
  logic               VALID;
  logic               FRAME_ERR;
  logic [7:0]         ERR_CNT;
  logic               BUSY;
  int tests = 0;
  int fails = 0;
  int n_valid = 0;
  int n_err = 0;
  int vb, eb;
  logic [23:0] vq[$];

  dac_frame_rx dut (
    .CLK_50(CLK_50), .RESET_N(RESET_N), .SYNC(SYNC), .SCLK(SCLK), .DIN(DIN),
    .DATA24(DATA24), .CTRL8(CTRL8), .VALID(VALID), .FRAME_ERR(FRAME_ERR),
    .ERR_CNT(ERR_CNT), .BUSY(BUSY)
  );

  always #10 CLK_50 = ~CLK_50;

  always @(negedge CLK_50) if (RESET_N) begin
    if (VALID) begin
      n_valid++;
      vq.push_back(DATA24);
    end
    if (FRAME_ERR) n_err++;
  end

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK_50);
      #1;
    end
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    SYNC = 1'b0;
    tick(3);
    for (int i = n - 1; i >= 0; i--) begin
      DIN = bits[i];
      SCLK = 1'b0;
      tick(2);
      SCLK = 1'b1;
      tick(1);
    end
    SCLK = 1'b0;
    DIN = 1'b0;
    tick(3);
  endtask

  task automatic frame(input logic [31:0] bits, input int n, input int gap);
    send_bits(bits, n);
    SYNC = 1'b1;
    tick(gap);
  endtask

  initial begin
    tick(3);
    check("rst_data", DATA24, 24'h0);
    check("rst_ctrl", {16'h0, CTRL8}, 24'h0);
    check("rst_valid", {23'h0, VALID}, 24'h0);
    check("rst_ferr", {23'h0, FRAME_ERR}, 24'h0);
    check("rst_errcnt", {16'h0, ERR_CNT}, 24'h0);
    check("rst_busy", {23'h0, BUSY}, 24'h0);
    RESET_N = 1'b1;
    tick(5);
    // good frame with latency check: SYNC high sampled at e0, VALID after e3
    send_bits(32'h008001, 24);
    check("f1_busy", {23'h0, BUSY}, 24'h1);
    SYNC = 1'b1;
    tick(3);
    check("f1_early", {23'h0, VALID}, 24'h0);
    tick(1);
    check("f1_valid", {23'h0, VALID}, 24'h1);
    check("f1_data", DATA24, 24'h800100);
    check("f1_ctrl", {16'h0, CTRL8}, 24'h0);
    tick(1);
    check("f1_pulse1", {23'h0, VALID}, 24'h0);
    tick(4);
    check("f1_nvalid", n_valid[23:0], 24'd1);
    check("f1_errcnt", {16'h0, ERR_CNT}, 24'h0);
    check("f1_idle", {23'h0, BUSY}, 24'h0);
    // short then long frame
    frame(32'h7fffff, 23, 6);
    frame(32'h1ffffff, 25, 6);
    check("sl_nerr", n_err[23:0], 24'd2);
    check("sl_errcnt", {16'h0, ERR_CNT}, 24'd2);
    check("sl_data", DATA24, 24'h800100);
    check("sl_nvalid", n_valid[23:0], 24'd1);
    // non-zero control byte
    frame(32'h5a1234, 24, 6);
`ifdef DAC_FRAME_RX_CTRL_CHECK_EN
    check("ctl_nerr", n_err[23:0], 24'd3);
    check("ctl_errcnt", {16'h0, ERR_CNT}, 24'd3);
    check("ctl_data", DATA24, 24'h800100);
    check("ctl_ctrl", {16'h0, CTRL8}, 24'h0);
`else
    check("ctl_nvalid", n_valid[23:0], 24'd2);
    check("ctl_ctrl", {16'h0, CTRL8}, 24'h5a);
    check("ctl_data", DATA24, 24'h123400);
    check("ctl_errcnt", {16'h0, ERR_CNT}, 24'd2);
`endif
    // back-to-back with one cycle of SYNC high between
    vb = n_valid;
    frame(32'h002222, 24, 1);
    frame(32'h00c3a5, 24, 6);
    check("b2b_nvalid", n_valid[23:0], 24'(vb + 2));
    check("b2b_first", (vq.size() > vb) ? vq[vb] : 24'hx, 24'h222200);
    check("b2b_second", (vq.size() > vb + 1) ? vq[vb+1] : 24'hx, 24'hc3a500);
    // empty frames saturate the error counter
    eb = n_err;
    repeat (260) begin
      SYNC = 1'b0;
      tick(3);
      SYNC = 1'b1;
      tick(3);
    end
    tick(3);
    check("sat_nerr", n_err[23:0], 24'(eb + 260));
    check("sat_errcnt", {16'h0, ERR_CNT}, 24'd255);
    check("sat_data", DATA24, 24'hc3a500);
    // reset mid-frame with SYNC still low at release
    vb = n_valid;
    eb = n_err;
    send_bits(32'habc, 12);
    RESET_N = 1'b0;
    tick(2);
    check("mr_errcnt", {16'h0, ERR_CNT}, 24'h0);
    check("mr_data", DATA24, 24'h0);
    RESET_N = 1'b1;
    tick(8);
    check("mr_busy", {23'h0, BUSY}, 24'h0);
    check("mr_nerr", n_err[23:0], 24'(eb));
    check("mr_nvalid", n_valid[23:0], 24'(vb));
    SYNC = 1'b1;
    tick(4);
    frame(32'h00abcd, 24, 6);
    check("mr_next_data", DATA24, 24'habcd00);
    check("mr_next_nvalid", n_valid[23:0], 24'(vb + 1));
    check("mr_next_nerr", n_err[23:0], 24'(eb));
    check("mr_next_errcnt", {16'h0, ERR_CNT}, 24'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
